pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for an in-order pipeline: per-latch enables, bubbles, valid tracking, HALT drain.
// Optional performance counters are enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int STAGES  = 5,
  parameter int REGBITS = 5,
  parameter int CNTW    = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ihit,
  input  logic                dmem_req,
  input  logic                dhit,
  input  logic                ex_memread,
  input  logic [REGBITS-1:0]  ex_wsel,
  input  logic [REGBITS-1:0]  id_rs,
  input  logic [REGBITS-1:0]  id_rt,
  input  logic                branch_taken,
  input  logic                id_halt,
  output logic                pc_en,
  output logic [STAGES-2:0]   latch_wen,
  output logic [STAGES-2:0]   latch_flush,
  output logic [STAGES-2:0]   valid,
  output logic                halted,
  output logic [1:0]          dbg_state_o
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [CNTW-1:0]     stall_cycles,
  output logic [CNTW-1:0]     flush_count
`endif
);

  localparam int NL = STAGES - 1;
  localparam int CW = $clog2(STAGES);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NL-1:0]   valid_q, valid_d;
  logic            halted_q;
  logic            br_pend_q, br_pend_d;

  logic            mem_stall;
  logic            br_flush;
  logic            load_use;
  logic            halt_pend;
  logic            fetch_ok;
  logic            halt_set;

  always_comb begin
    mem_stall = dmem_req & ~dhit;
    // A branch seen while MEM stalls stays pending until EX can move again.
    br_flush  = (branch_taken | br_pend_q) & valid_q[1];
    load_use  = ex_memread & valid_q[1] & valid_q[0] & (ex_wsel != '0) &
                ((ex_wsel == id_rs) | (ex_wsel == id_rt));
    halt_pend = (state_q == ST_DRAIN);
    fetch_ok  = ihit & ~halt_pend;

    pc_en       = 1'b0;
    latch_wen   = '0;
    latch_flush = '0;
    valid_d     = valid_q;
    halt_set    = 1'b0;

    if (halted_q) begin
      valid_d = '0;
    end else if (mem_stall) begin
      valid_d = valid_q;
    end else if (br_flush) begin
      pc_en            = 1'b1;
      latch_wen        = '1;
      latch_flush[1:0] = 2'b11;
      valid_d          = {valid_q[NL-2:0], 1'b0};
      valid_d[1]       = 1'b0;
    end else if (load_use) begin
      latch_wen      = '1;
      latch_wen[0]   = 1'b0;
      latch_flush[1] = 1'b1;
      latch_flush[0] = halt_pend;
      valid_d        = {valid_q[NL-2:0], valid_q[0] & ~halt_pend};
      valid_d[1]     = 1'b0;
    end else begin
      pc_en          = fetch_ok;
      latch_wen      = '1;
      latch_flush[0] = ~fetch_ok;
      valid_d        = {valid_q[NL-2:0], fetch_ok};
      halt_set       = id_halt & valid_q[0] & (state_q == ST_RUN);
    end

    if (!nRST) begin
      pc_en       = 1'b0;
      latch_wen   = '0;
      latch_flush = '0;
    end

    br_pend_d = mem_stall & br_flush & ~halted_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_set) begin
          state_d = ST_DRAIN;
          cnt_d   = CW'(NL);
        end
      end
      ST_DRAIN: begin
        // The HALT was fetched on a mispredicted path if a branch resolves behind it.
        if (br_flush && !mem_stall) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_HALTED;
        end else if (!mem_stall) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      valid_q   <= '0;
      halted_q  <= 1'b0;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      halted_q  <= (state_d == ST_HALTED);
      br_pend_q <= br_pend_d;
    end
  end

  assign valid       = valid_q;
  assign halted      = halted_q;
  assign dbg_state_o = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic            stall_inc;
  logic            flush_inc;
  logic [CNTW-1:0] stall_q;
  logic [CNTW-1:0] flush_q;

  assign stall_inc = ~halted_q & (mem_stall | (~br_flush & (load_use | ~ihit)));
  assign flush_inc = ~halted_q & ~mem_stall & br_flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNTW'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNTW'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (STAGES=5, CNTW=4): driver pushes expected per-cycle outputs, monitor compares.
module tb_pipeline_ctrl;
  localparam int W = 14;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dmem_req, dhit, ex_memread, branch_taken, id_halt;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic       pc_en, halted;
  logic [3:0] latch_wen, latch_flush, valid;
  logic [1:0] dbg_state_o;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [3:0] stall_cycles, flush_count;
`endif

  pipeline_ctrl #(.STAGES(5), .REGBITS(5), .CNTW(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .ex_memread(ex_memread), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .branch_taken(branch_taken), .id_halt(id_halt), .pc_en(pc_en),
    .latch_wen(latch_wen), .latch_flush(latch_flush), .valid(valid),
    .halted(halted), .dbg_state_o(dbg_state_o)
`ifdef PIPELINE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 CLK = ~CLK;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;

  // Expected word layout: {pc_en, latch_wen[3:0], latch_flush[3:0], valid[3:0], halted}
  always @(negedge CLK) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {pc_en, latch_wen, latch_flush, valid, halted};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got pc_en=%b wen=%b flush=%b valid=%b halted=%b, want pc_en=%b wen=%b flush=%b valid=%b halted=%b",
                 nm, a[13], a[12:9], a[8:5], a[4:1], a[0], e[13], e[12:9], e[8:5], e[4:1], e[0]);
      end
    end
  end

  task automatic cyc(input string nm, input logic p, input logic [3:0] w,
                     input logic [3:0] f, input logic [3:0] v, input logic h);
    exp_q.push_back({p, w, f, v, h});
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0; ex_memread = 1'b0;
    ex_wsel = '0; id_rs = '0; id_rt = '0; branch_taken = 1'b0; id_halt = 1'b0;
  endtask

`ifdef PIPELINE_CTRL_PERF_EN
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    cyc("reset", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    nRST = 1'b1;

    // Fill from empty
    cyc("fill0", 1'b1, 4'hF, 4'h0, 4'b0000, 1'b0);
    cyc("fill1", 1'b1, 4'hF, 4'h0, 4'b0001, 1'b0);
    cyc("fill2", 1'b1, 4'hF, 4'h0, 4'b0011, 1'b0);
    cyc("fill3", 1'b1, 4'hF, 4'h0, 4'b0111, 1'b0);
    cyc("fill4", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);

    // Load-use on rt, then bubble drains through
    ex_memread = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5;
    cyc("lu_rt", 1'b0, 4'b1110, 4'b0010, 4'b1111, 1'b0);
    cyc("lu_after", 1'b1, 4'hF, 4'h0, 4'b1101, 1'b0);
    idle();
    cyc("lu_b1", 1'b1, 4'hF, 4'h0, 4'b1011, 1'b0);
    cyc("lu_b2", 1'b1, 4'hF, 4'h0, 4'b0111, 1'b0);
    ex_memread = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    cyc("lu_r0", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);
    ex_wsel = 5'd3; id_rs = 5'd3; id_rt = 5'd7;
    cyc("lu_rs", 1'b0, 4'b1110, 4'b0010, 4'b1111, 1'b0);
    idle();
    cyc("lu_c1", 1'b1, 4'hF, 4'h0, 4'b1101, 1'b0);
    cyc("lu_c2", 1'b1, 4'hF, 4'h0, 4'b1011, 1'b0);
    cyc("lu_c3", 1'b1, 4'hF, 4'h0, 4'b0111, 1'b0);
    cyc("lu_c4", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);

    // Mem-stall holds a taken branch off until the stall releases
    dmem_req = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
    cyc("ms1", 1'b0, 4'h0, 4'h0, 4'b1111, 1'b0);
    cyc("ms2", 1'b0, 4'h0, 4'h0, 4'b1111, 1'b0);
    cyc("ms3", 1'b0, 4'h0, 4'h0, 4'b1111, 1'b0);
    idle();
    cyc("ms_br", 1'b1, 4'hF, 4'b0011, 4'b1111, 1'b0);
    cyc("br_a1", 1'b1, 4'hF, 4'h0, 4'b1100, 1'b0);
    cyc("br_a2", 1'b1, 4'hF, 4'h0, 4'b1001, 1'b0);
    cyc("br_a3", 1'b1, 4'hF, 4'h0, 4'b0011, 1'b0);
    cyc("br_a4", 1'b1, 4'hF, 4'h0, 4'b0111, 1'b0);
    cyc("br_a5", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);

    // Icache miss
    ihit = 1'b0;
    cyc("ic_miss", 1'b0, 4'hF, 4'b0001, 4'b1111, 1'b0);
    ihit = 1'b1;
    cyc("ic_a1", 1'b1, 4'hF, 4'h0, 4'b1110, 1'b0);
    cyc("ic_a2", 1'b1, 4'hF, 4'h0, 4'b1101, 1'b0);
    cyc("ic_a3", 1'b1, 4'hF, 4'h0, 4'b1011, 1'b0);
    cyc("ic_a4", 1'b1, 4'hF, 4'h0, 4'b0111, 1'b0);
    cyc("ic_a5", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);

    // HALT cancelled by a taken branch one cycle later
    id_halt = 1'b1;
    cyc("hc_cap", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);
    idle(); branch_taken = 1'b1;
    cyc("hc_br", 1'b1, 4'hF, 4'b0011, 4'b1111, 1'b0);
    idle();
    cyc("hc_r1", 1'b1, 4'hF, 4'h0, 4'b1100, 1'b0);
    cyc("hc_r2", 1'b1, 4'hF, 4'h0, 4'b1001, 1'b0);
    cyc("hc_r3", 1'b1, 4'hF, 4'h0, 4'b0011, 1'b0);
    cyc("hc_r4", 1'b1, 4'hF, 4'h0, 4'b0111, 1'b0);
    cyc("hc_r5", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);
`ifdef PIPELINE_CTRL_PERF_EN
    chk("stall_cycles_mix", stall_cycles, 4'd6);
    chk("flush_count_mix", flush_count, 4'd2);
`endif

    // Reset in the middle of a drain discards the pending halt
    id_halt = 1'b1;
    cyc("dr_cap", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);
    idle();
    cyc("dr_pend", 1'b0, 4'hF, 4'b0001, 4'b1111, 1'b0);
    nRST = 1'b0;
    cyc("dr_rst", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    nRST = 1'b1;
    cyc("dr_rel", 1'b1, 4'hF, 4'h0, 4'b0000, 1'b0);
    cyc("dr_f1", 1'b1, 4'hF, 4'h0, 4'b0001, 1'b0);
    cyc("dr_f2", 1'b1, 4'hF, 4'h0, 4'b0011, 1'b0);
    cyc("dr_f3", 1'b1, 4'hF, 4'h0, 4'b0111, 1'b0);
    cyc("dr_f4", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);

    // Full HALT drain: halted rises five edges after capture
    id_halt = 1'b1;
    cyc("h_cap", 1'b1, 4'hF, 4'h0, 4'b1111, 1'b0);
    idle();
    cyc("h_d1", 1'b0, 4'hF, 4'b0001, 4'b1111, 1'b0);
    cyc("h_d2", 1'b0, 4'hF, 4'b0001, 4'b1110, 1'b0);
    cyc("h_d3", 1'b0, 4'hF, 4'b0001, 4'b1100, 1'b0);
    cyc("h_d4", 1'b0, 4'hF, 4'b0001, 4'b1000, 1'b0);
    cyc("h_d5", 1'b0, 4'hF, 4'b0001, 4'b0000, 1'b0);
    cyc("h_done", 1'b0, 4'h0, 4'h0, 4'b0000, 1'b1);
    branch_taken = 1'b1;
    cyc("h_sticky", 1'b0, 4'h0, 4'h0, 4'b0000, 1'b1);
    idle();

`ifdef PIPELINE_CTRL_PERF_EN
    nRST = 1'b0;
    cyc("p_rst", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    nRST = 1'b1;
    ihit = 1'b0;
    repeat (5) cyc("p_miss", 1'b0, 4'hF, 4'b0001, 4'b0000, 1'b0);
    chk("stall_cycles_5", stall_cycles, 4'd5);
    repeat (15) cyc("p_miss", 1'b0, 4'hF, 4'b0001, 4'b0000, 1'b0);
    chk("stall_cycles_sat", stall_cycles, 4'd15);
    chk("flush_count_zero", flush_count, 4'd0);
    idle();
`endif

    repeat (4) if (exp_q.size() != 0) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
